// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: D-cache miss sequencing, load-use bubbles, branch squash and EX forwarding.
// Optional perf counters are built only when HAZ_PERF_CNT_EN is defined (otherwise stall_cnt/flush_cnt read 0).
module hazard_ctrl_unit #(
   parameter int MISS_TIMEOUT = 64,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic             dcache_req,
   input  logic             dcache_ready,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             stall_mem,
   output logic             stall_wb,
   output logic             flush_id,
   output logic             flush_ex,
   output logic             flush_wb,
   output logic             pc_redirect,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic             err_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             o_dbg_state
);

   localparam int WAIT_W = $clog2(MISS_TIMEOUT + 1);

   typedef enum logic {ST_RUN = 1'b0, ST_DWAIT = 1'b1} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [WAIT_W-1:0]   w_wait_nxt;
   logic                r_err_timeout;
   logic                w_err_set;
   logic                w_miss;
   logic                w_load_use;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_err_set) r_err_timeout <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_err_set   = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (dcache_req && !dcache_ready) begin
               w_state_nxt = ST_DWAIT;
               w_wait_nxt  = WAIT_W'(1);
            end
         end
         ST_DWAIT: begin
            if (dcache_ready) begin
               w_state_nxt = ST_RUN;
            end else if (r_wait_cnt == WAIT_W'(MISS_TIMEOUT - 1)) begin
               w_err_set   = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               w_wait_nxt = r_wait_cnt + WAIT_W'(1);
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign w_miss = ((r_state == ST_RUN) && dcache_req && !dcache_ready) ||
                   ((r_state == ST_DWAIT) && !dcache_ready);

   assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   // Outputs: a miss freezes everything up to MEM and drops the MEM/WB write so it is not repeated
   always_comb begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      stall_mem   = 1'b0;
      stall_wb    = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      flush_wb    = 1'b0;
      pc_redirect = 1'b0;
      if (reset) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
         flush_wb = 1'b1;
      end else if (w_miss) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         stall_ex  = 1'b1;
         stall_mem = 1'b1;
         flush_wb  = 1'b1;
      end else if (ex_branch_taken) begin
         flush_id    = 1'b1;
         flush_ex    = 1'b1;
         pc_redirect = 1'b1;
      end else if (w_load_use) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         flush_ex = 1'b1;
      end
   end

   // Forwarding: EX/MEM takes precedence over MEM/WB; x0 is never forwarded
   always_comb begin
      forward_a = 2'b00;
      forward_b = 2'b00;
      if (!reset) begin
         if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs1))     forward_a = 2'b10;
         else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1))   forward_a = 2'b01;
         if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs2))     forward_b = 2'b10;
         else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2))   forward_b = 2'b01;
      end
   end

   assign err_timeout = r_err_timeout;
   // o_dbg_state is 1 while the controller is waiting on the D-cache
   assign o_dbg_state = (r_state == ST_DWAIT);

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall_if && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (flush_ex && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
